// File: rtl/mixcolum_seq_pkg.sv
// rtl/mixcolum_seq_pkg.sv - shared AES definitions for the sequential MixColumns engine
//
// Purpose : FSM state encoding, column width and the GF(2^8) xtime helper.
//           The xtime helper reduces by the polynomial 0x11B.
// Ports   : none (package)
package mixcolum_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         COL_W      = 32;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  // Multiply by {02} in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mixcolum_seq_word.sv
// rtl/mixcolum_seq_word.sv - combinational forward/inverse MixColumns for one 32-bit column
//
// Purpose : byte_mixcolum computes one output row from four rotated column bytes;
//           word_mixcolum instantiates four of them, one per output row.
// Ports   : byte_mixcolum  a,b,c,d [7:0] in ; fwd [7:0] out ; inv [7:0] out
//           word_mixcolum  col [31:0] in (row 0 in bits 31:24) ; fwd, inv [31:0] out
import mixcolum_seq_pkg::*;

module byte_mixcolum (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  output logic [7:0] fwd,
  output logic [7:0] inv
);

  // 02a ^ 03b ^ c ^ d
  assign fwd = xtime(a) ^ xtime(b) ^ b ^ c ^ d;

  // The inverse reuses the forward value: 04(a^c) ^ 08(a^b^c^d) added to the
  // forward coefficients yields 0E,0B,0D,09.
  assign inv = xtime(xtime(a ^ c ^ xtime(a ^ b) ^ xtime(c ^ d))) ^ fwd;

endmodule

module word_mixcolum (
  input  logic [COL_W-1:0] col,
  output logic [COL_W-1:0] fwd,
  output logic [COL_W-1:0] inv
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = col[31:24];
  assign b1 = col[23:16];
  assign b2 = col[15:8];
  assign b3 = col[7:0];

  // Row r takes the column rotated left by r bytes.
  byte_mixcolum u_row0 (.a(b0), .b(b1), .c(b2), .d(b3), .fwd(fwd[31:24]), .inv(inv[31:24]));
  byte_mixcolum u_row1 (.a(b1), .b(b2), .c(b3), .d(b0), .fwd(fwd[23:16]), .inv(inv[23:16]));
  byte_mixcolum u_row2 (.a(b2), .b(b3), .c(b0), .d(b1), .fwd(fwd[15:8]),  .inv(inv[15:8]));
  byte_mixcolum u_row3 (.a(b3), .b(b0), .c(b1), .d(b2), .fwd(fwd[7:0]),   .inv(inv[7:0]));

endmodule

// File: rtl/mixcolum_seq.sv
// rtl/mixcolum_seq.sv - sequential AES (Inv)MixColumns, one column per clock
//
// Purpose : loads a 128-bit state on start_i, mixes one column per cycle through a
//           single shared word_mixcolum, then holds the result with ready_o high.
// Ports   : clk        in   rising-edge clock
//           reset      in   asynchronous active-low reset
//           start_i    in   one-cycle request, accepted in IDLE or DONE
//           decrypt_i  in   1 = InvMixColumns, sampled with start_i
//           data_i     in   [127:0] state, column k = data_i[127-32k -: 32]
//           ready_o    out  high while data_o holds a completed result
//           data_o     out  [127:0] state register
// Macro   : MIXCOL_INV_EN - when defined, decrypt_i selects the inverse transform;
//           otherwise decrypt_i is ignored and only the forward path is used.
import mixcolum_seq_pkg::*;

module mixcolum_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         decrypt_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o
);

  state_t       state_q, state_d;
  logic [1:0]   col_cnt, col_cnt_d;
  logic [127:0] data_q, data_d;

  logic [COL_W-1:0] cur_col, col_fwd, mixed;
  logic [127:0]     data_merge;

  always_comb begin
    cur_col = data_q[127:96];
    case (col_cnt)
      2'd0: cur_col = data_q[127:96];
      2'd1: cur_col = data_q[95:64];
      2'd2: cur_col = data_q[63:32];
      2'd3: cur_col = data_q[31:0];
      default: cur_col = data_q[127:96];
    endcase
  end

`ifdef MIXCOL_INV_EN
  logic             dec_q, dec_d;
  logic [COL_W-1:0] col_inv;

  word_mixcolum u_word (.col(cur_col), .fwd(col_fwd), .inv(col_inv));

  assign mixed = dec_q ? col_inv : col_fwd;
`else
  // Inverse output left dangling so synthesis removes the inverse network.
  logic [COL_W-1:0] unused_inv;
  logic             unused_decrypt;

  word_mixcolum u_word (.col(cur_col), .fwd(col_fwd), .inv(unused_inv));

  assign mixed          = col_fwd;
  assign unused_decrypt = decrypt_i;
`endif

  always_comb begin
    data_merge = data_q;
    case (col_cnt)
      2'd0: data_merge[127:96] = mixed;
      2'd1: data_merge[95:64]  = mixed;
      2'd2: data_merge[63:32]  = mixed;
      2'd3: data_merge[31:0]   = mixed;
      default: data_merge = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_cnt <= 2'd0;
      data_q  <= 128'h0;
`ifdef MIXCOL_INV_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_cnt <= col_cnt_d;
      data_q  <= data_d;
`ifdef MIXCOL_INV_EN
      dec_q   <= dec_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt;
    data_d    = data_q;
`ifdef MIXCOL_INV_EN
    dec_d     = dec_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = BUSY;
          col_cnt_d = 2'd0;
          data_d    = data_i;
`ifdef MIXCOL_INV_EN
          dec_d     = decrypt_i;
`endif
        end
      end
      BUSY: begin
        // start_i is deliberately not looked at here.
        data_d    = data_merge;
        col_cnt_d = col_cnt + 2'd1;   // wraps 3->0 as the last column lands
        if (col_cnt == 2'd3) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == DONE);
  assign data_o  = data_q;

endmodule

// File: tb/tb_mixcolum_seq.sv
// tb/tb_mixcolum_seq.sv - directed self-checking bench for mixcolum_seq
module tb_mixcolum_seq;

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] C6_VEC  = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
  localparam logic [127:0] D4_IN   = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [127:0] D4_OUT  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
  localparam logic [127:0] JUNK    = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic         clk;
  logic         reset;
  logic         start_i;
  logic         decrypt_i;
  logic [127:0] data_i;
  logic         ready_o;
  logic [127:0] data_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;

  mixcolum_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .decrypt_i (decrypt_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .data_o    (data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called one negedge after the sampling edge; counts further edges until ready_o.
  task automatic wait_ready(input int already, output int n);
    n = already;
    for (int i = 0; i < 12; i++) begin
      if (ready_o) break;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [127:0] din, input logic dec,
                        input logic [127:0] dexp);
    int n;
    @(negedge clk);
    start_i = 1'b1; data_i = din; decrypt_i = dec;
    @(negedge clk);
    start_i = 1'b0; decrypt_i = 1'b0; data_i = JUNK;
    check({tag, "_ready_low"}, {127'h0, ready_o}, 128'h0);
    wait_ready(0, n);
    check({tag, "_latency"}, 128'(n), 128'd4);
    check({tag, "_data"}, data_o, dexp);
  endtask

  initial begin
    reset = 1'b0; start_i = 1'b0; decrypt_i = 1'b0; data_i = 128'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {127'h0, ready_o}, 128'h0);
    check("rst_data", data_o, 128'h0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_ready", {127'h0, ready_o}, 128'h0);

    run_op("fwd", FWD_IN, 1'b0, FWD_OUT);

    data_i = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    repeat (3) @(negedge clk);
    check("hold_ready", {127'h0, ready_o}, 128'h1);
    check("hold_data", data_o, FWD_OUT);

    start_i = 1'b1; data_i = FWD_IN; decrypt_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1; data_i = JUNK; decrypt_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; decrypt_i = 1'b0;
    wait_ready(2, lat);
    check("ignore_latency", 128'(lat), 128'd4);
    check("ignore_data", data_o, FWD_OUT);

    @(negedge clk);
    start_i = 1'b1; data_i = FWD_IN; decrypt_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", {127'h0, ready_o}, 128'h0);
    check("abort_data", data_o, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    run_op("c6", C6_VEC, 1'b0, C6_VEC);

    run_op("b2b", D4_IN, 1'b0, D4_OUT);

`ifdef MIXCOL_INV_EN
    run_op("inv", FWD_OUT, 1'b1, FWD_IN);
`else
    run_op("noinv", FWD_IN, 1'b1, FWD_OUT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
